rtn_addr_stack: RTL and testbench

- Hardware return-address stack (LIFO) that produces Return_Addr for the program counter.
- On a call, the sequencer asserts Push_Rtn and the block stores PC+1. On a return, it asserts Pop_Rtn together with the PC's Ld_Rtn_Addr; the PC loads the current top-of-stack from Return_Addr in that same cycle, and the entry is discarded at the clock edge.
- Sits beside the program counter in the control path. Also gives sticky overflow/underflow status to the control unit.

---
 rtl/rtn_addr_stack.sv | 123 ++++++++++++
 tb/tb_rtn_addr_stack.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/rtn_addr_stack.sv
`default_nettype none
// ============================================================================
// Module   : rtn_addr_stack
// Brief    : Hardware return-address stack (LIFO) for the program counter.
//            A call pushes PC+1, a return discards the top entry while the PC
//            loads Return_Addr in the same cycle. Sticky overflow/underflow
//            status is kept for the control unit.
//            Optional build macro RAS_OVF_WRAP_EN: when defined, storage acts
//            as a circular buffer and a push while full overwrites the oldest
//            entry; when undefined, a push while full is rejected.
// Revision : 1.0 - initial release
// ============================================================================
module rtn_addr_stack #(
    parameter int DEPTH = 8,
    parameter int AW    = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   Push_Rtn,
    input  logic                   Pop_Rtn,
    input  logic [AW-1:0]          PC,
    input  logic                   Clr_Err,
    output logic [AW-1:0]          Return_Addr,
    output logic                   Stack_Empty,
    output logic                   Stack_Full,
    output logic [$clog2(DEPTH):0] Stack_Cnt,
    output logic                   Stack_Ovf,
    output logic                   Stack_Unf
);

    localparam int              c_PW    = $clog2(DEPTH);
    localparam logic [c_PW:0]   c_DEPTH = (c_PW + 1)'(DEPTH);

    // r_sp points at the next free slot; the top entry lives at r_sp-1.
    logic [AW-1:0]   r_mem [DEPTH];
    logic [c_PW-1:0] r_sp;
    logic [c_PW:0]   r_cnt;
    logic            r_ovf;
    logic            r_unf;

    logic            w_empty;
    logic            w_full;
    logic [c_PW-1:0] w_top_idx;
    logic [AW-1:0]   w_push_val;
    logic            w_we;
    logic [c_PW-1:0] w_waddr;
    logic [c_PW-1:0] w_sp_nxt;
    logic [c_PW:0]   w_cnt_nxt;
    logic            w_ovf_evt;
    logic            w_unf_evt;

    assign w_empty    = (r_cnt == '0);
    assign w_full     = (r_cnt == c_DEPTH);
    assign w_top_idx  = r_sp - c_PW'(1);
    assign w_push_val = PC + AW'(1);

    // Decode the requested operation into a storage write and pointer/count update.
    always_comb begin
        w_we      = 1'b0;
        w_waddr   = r_sp;
        w_sp_nxt  = r_sp;
        w_cnt_nxt = r_cnt;
        w_ovf_evt = 1'b0;
        w_unf_evt = 1'b0;
        if (Push_Rtn && Pop_Rtn && !w_empty) begin
            // Return immediately followed by a call: replace the top in place.
            w_we    = 1'b1;
            w_waddr = w_top_idx;
        end else if (Push_Rtn) begin
            if (!w_full) begin
                w_we      = 1'b1;
                w_sp_nxt  = r_sp + c_PW'(1);
                w_cnt_nxt = r_cnt + (c_PW + 1)'(1);
            end else begin
                w_ovf_evt = 1'b1;
`ifdef RAS_OVF_WRAP_EN
                // When full, the free-slot pointer aliases the oldest entry,
                // so writing there drops the oldest and makes the new one top.
                w_we     = 1'b1;
                w_sp_nxt = r_sp + c_PW'(1);
`endif
            end
        end else if (Pop_Rtn) begin
            if (!w_empty) begin
                w_sp_nxt  = r_sp - c_PW'(1);
                w_cnt_nxt = r_cnt - (c_PW + 1)'(1);
            end else begin
                w_unf_evt = 1'b1;
            end
        end
    end

    // Pointer, count and sticky status registers; a new event beats Clr_Err.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sp  <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_sp  <= w_sp_nxt;
            r_cnt <= w_cnt_nxt;
            r_ovf <= w_ovf_evt | (r_ovf & ~Clr_Err);
            r_unf <= w_unf_evt | (r_unf & ~Clr_Err);
        end
    end

    // Entry storage; contents need no reset because the count masks them.
    always_ff @(posedge clk) begin
        if (!reset && w_we) begin
            r_mem[w_waddr] <= w_push_val;
        end
    end

    assign Return_Addr = w_empty ? '0 : r_mem[w_top_idx];
    assign Stack_Empty = w_empty;
    assign Stack_Full  = w_full;
    assign Stack_Cnt   = r_cnt;
    assign Stack_Ovf   = r_ovf;
    assign Stack_Unf   = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_rtn_addr_stack.sv
`default_nettype none
// ============================================================================
// Module   : tb_rtn_addr_stack
// Brief    : Scoreboard bench for rtn_addr_stack. Directed vectors carry
//            hand-computed post-edge expectations that are queued at each
//            edge; an independent monitor pops and compares them.
//            Honours RAS_OVF_WRAP_EN the same way as the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rtn_addr_stack;

    localparam int c_DEPTH = 8;
    localparam int c_AW    = 8;

    typedef struct packed {
        logic [7:0] ra;
        logic [3:0] cnt;
        logic       ovf;
        logic       unf;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       Push_Rtn;
    logic       Pop_Rtn;
    logic [7:0] PC;
    logic       Clr_Err;
    logic [7:0] Return_Addr;
    logic       Stack_Empty;
    logic       Stack_Full;
    logic [3:0] Stack_Cnt;
    logic       Stack_Ovf;
    logic       Stack_Unf;

    exp_t q_exp [$];
    int   n_checks;
    int   n_fail;
    int   n_step;

    rtn_addr_stack #(
        .DEPTH(c_DEPTH),
        .AW   (c_AW)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .Push_Rtn   (Push_Rtn),
        .Pop_Rtn    (Pop_Rtn),
        .PC         (PC),
        .Clr_Err    (Clr_Err),
        .Return_Addr(Return_Addr),
        .Stack_Empty(Stack_Empty),
        .Stack_Full (Stack_Full),
        .Stack_Cnt  (Stack_Cnt),
        .Stack_Ovf  (Stack_Ovf),
        .Stack_Unf  (Stack_Unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    // Monitor: every edge the DUT presents a new state; compare with the queue.
    initial begin
        int idx;
        exp_t e;
        idx = 0;
        forever begin
            @(posedge clk);
            #1;
            if (q_exp.size() > 0) begin
                e = q_exp.pop_front();
                check("Return_Addr", idx, 32'(Return_Addr), 32'(e.ra));
                check("Stack_Cnt",   idx, 32'(Stack_Cnt),   32'(e.cnt));
                check("Stack_Empty", idx, 32'(Stack_Empty), 32'(e.cnt == 4'd0));
                check("Stack_Full",  idx, 32'(Stack_Full),  32'(e.cnt == 4'd8));
                check("Stack_Ovf",   idx, 32'(Stack_Ovf),   32'(e.ovf));
                check("Stack_Unf",   idx, 32'(Stack_Unf),   32'(e.unf));
                idx++;
            end
        end
    end

    // Drive one cycle of inputs and queue the state expected after the edge.
    task automatic step(input logic rst, input logic psh, input logic pop,
                        input logic [7:0] pc, input logic clr,
                        input logic [7:0] e_ra, input logic [3:0] e_cnt,
                        input logic e_ovf, input logic e_unf);
        exp_t e;
        reset    = rst;
        Push_Rtn = psh;
        Pop_Rtn  = pop;
        PC       = pc;
        Clr_Err  = clr;
        e.ra  = e_ra;
        e.cnt = e_cnt;
        e.ovf = e_ovf;
        e.unf = e_unf;
        @(posedge clk);
        q_exp.push_back(e);
        n_step++;
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        n_step   = 0;
        reset    = 1'b1;
        Push_Rtn = 1'b0;
        Pop_Rtn  = 1'b0;
        PC       = 8'h00;
        Clr_Err  = 1'b0;
        @(negedge clk);

        //   rst psh pop  pc     clr   ra     cnt  ovf  unf
        // Reset for two cycles
        step(1, 0, 0, 8'h00, 0, 8'h00, 4'd0, 0, 0);
        step(1, 0, 0, 8'h00, 0, 8'h00, 4'd0, 0, 0);
        // Nested calls and returns
        step(0, 1, 0, 8'h10, 0, 8'h11, 4'd1, 0, 0);
        step(0, 1, 0, 8'h20, 0, 8'h21, 4'd2, 0, 0);
        step(0, 1, 0, 8'h30, 0, 8'h31, 4'd3, 0, 0);
        step(0, 0, 1, 8'h00, 0, 8'h21, 4'd2, 0, 0);
        step(0, 0, 1, 8'h00, 0, 8'h11, 4'd1, 0, 0);
        step(0, 0, 1, 8'h00, 0, 8'h00, 4'd0, 0, 0);
        // PC+1 wraps to zero; simultaneous push/pop replaces top
        step(0, 1, 0, 8'hFF, 0, 8'h00, 4'd1, 0, 0);
        step(0, 1, 0, 8'h04, 0, 8'h05, 4'd2, 0, 0);
        step(0, 1, 1, 8'h40, 0, 8'h41, 4'd2, 0, 0);
        step(0, 0, 1, 8'h00, 0, 8'h00, 4'd1, 0, 0);
        step(0, 0, 1, 8'h00, 0, 8'h00, 4'd0, 0, 0);
        // Push+pop while empty acts as a push, no underflow
        step(0, 1, 1, 8'h07, 0, 8'h08, 4'd1, 0, 0);
        step(0, 0, 1, 8'h00, 0, 8'h00, 4'd0, 0, 0);
        // Underflow is sticky, cleared by Clr_Err, new event beats the clear
        step(0, 0, 1, 8'h00, 0, 8'h00, 4'd0, 0, 1);
        step(0, 0, 0, 8'h00, 0, 8'h00, 4'd0, 0, 1);
        step(0, 0, 0, 8'h00, 1, 8'h00, 4'd0, 0, 0);
        step(0, 0, 1, 8'h00, 1, 8'h00, 4'd0, 0, 1);
        step(0, 0, 0, 8'h00, 1, 8'h00, 4'd0, 0, 0);
        // Reset mid-sequence discards entries and beats a same-cycle push
        step(0, 1, 0, 8'h60, 0, 8'h61, 4'd1, 0, 0);
        step(1, 1, 0, 8'h70, 0, 8'h00, 4'd0, 0, 0);
        step(0, 0, 1, 8'h00, 0, 8'h00, 4'd0, 0, 1);
        step(0, 0, 0, 8'h00, 1, 8'h00, 4'd0, 0, 0);
        // Fill the stack
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 0, 8'(i), 0, 8'(i + 1), 4'(i + 1), 0, 0);
        end
`ifdef RAS_OVF_WRAP_EN
        // Push while full drops the oldest (0x01); pops yield 51,08..02
        step(0, 1, 0, 8'h50, 0, 8'h51, 4'd8, 1, 0);
        for (int i = 0; i < 7; i++) begin
            step(0, 0, 1, 8'h00, 0, 8'(8 - i), 4'(7 - i), 1, 0);
        end
        step(0, 0, 1, 8'h00, 0, 8'h00, 4'd0, 1, 0);
`else
        // Push while full is rejected; pops yield 08..01
        step(0, 1, 0, 8'h50, 0, 8'h08, 4'd8, 1, 0);
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 1, 8'h00, 0, 8'(7 - i), 4'(7 - i), 1, 0);
        end
`endif
        // Ninth pop underflows; then clear both flags
        step(0, 0, 1, 8'h00, 0, 8'h00, 4'd0, 1, 1);
        step(0, 0, 0, 8'h00, 1, 8'h00, 4'd0, 0, 0);

        // Let the monitor drain, bounded.
        for (int w = 0; w < 20 && q_exp.size() > 0; w++) @(negedge clk);
        check("scoreboard_drained", n_step, 32'(q_exp.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
